// File: rtl/uart_pkg.sv
// Shared UART package: FSM state encoding for the TX scheduler and the
// default frame/gap/byte constants that uart_tx also builds against.
package uart_pkg;

  // Scheduler FSM states; encoding is fixed so traces line up across blocks
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_GRANT = 3'd1,
    ST_TRIG  = 3'd2,
    ST_SEND  = 3'd3,
    ST_GAP   = 3'd4
  } sched_state_e;

  localparam int DATA_W_DEF      = 8;
  localparam int FRAME_TICKS_DEF = 10;  // start + 8 data + stop
  localparam int GAP_TICKS_DEF   = 1;

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational winner select for uart_tx_sched.
// Default build: round-robin, search starts one past last_grant.
// UART_TX_SCHED_FIXED_PRIO_EN defined: lowest valid index always wins.
module uart_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [ID_W-1:0]    last_grant,
  output logic               any_valid,
  output logic [ID_W-1:0]    pick_id
);

  assign any_valid = |req_valid;

`ifdef UART_TX_SCHED_FIXED_PRIO_EN
  // last_grant has no say in a fixed-priority pick
  logic unused_last;
  assign unused_last = ^last_grant;

  // Walk downward so the lowest valid index is the last one written
  always_comb begin
    pick_id = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) pick_id = ID_W'(i);
    end
  end
`else
  int                 idx;
  logic [NUM_REQ-1:0] sh;
  logic               found;

  // First valid requester at or after last_grant+1, wrapping mod NUM_REQ
  always_comb begin
    pick_id = '0;
    found   = 1'b0;
    idx     = 0;
    sh      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last_grant) + k) % NUM_REQ;
      sh  = req_valid >> idx;
      if (!found && sh[0]) begin
        found   = 1'b1;
        pick_id = ID_W'(idx);
      end
    end
  end
`endif

endmodule

// File: rtl/uart_tx_sched.sv
// Shares one uart_tx among NUM_REQ byte producers. One byte per
// valid/ready handshake, then grants are held off until the frame
// (FRAME_TICKS baud ticks) plus GAP_TICKS idle ticks have elapsed.
// Build option: UART_TX_SCHED_FIXED_PRIO_EN (inside uart_rr_pick) swaps
// round-robin for fixed lowest-index priority; timing is unchanged.
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int FRAME_TICKS = FRAME_TICKS_DEF,
  parameter int GAP_TICKS   = GAP_TICKS_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        baud_tick,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic                        tx_trig,
  output logic [DATA_W-1:0]           tx_byte,
  output logic [$clog2(NUM_REQ)-1:0]  grant_id,
  output logic                        busy
);

  localparam int ID_W   = $clog2(NUM_REQ);
  localparam int CNT_W  = $clog2(imax(FRAME_TICKS, GAP_TICKS) + 1);
  localparam int GAP_M1 = (GAP_TICKS > 0) ? GAP_TICKS - 1 : 0;

  localparam logic [CNT_W-1:0]   FRAME_LAST = CNT_W'(FRAME_TICKS - 1);
  localparam logic [CNT_W-1:0]   GAP_LAST   = CNT_W'(GAP_M1);
  localparam logic [NUM_REQ-1:0] ONE        = NUM_REQ'(1);
  localparam logic [ID_W-1:0]    LAST_RST   = ID_W'(NUM_REQ - 1);

  sched_state_e     state;
  logic [ID_W-1:0]  last_grant;
  logic [CNT_W-1:0] tick_cnt;
  logic             pick_any;
  logic [ID_W-1:0]  pick_id;

  uart_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_pick (
    .req_valid  (req_valid),
    .last_grant (last_grant),
    .any_valid  (pick_any),
    .pick_id    (pick_id)
  );

  // Scheduler FSM; every output is a register updated alongside the state
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      last_grant <= LAST_RST;
      tick_cnt   <= '0;
      req_ready  <= '0;
      tx_trig    <= 1'b0;
      tx_byte    <= '0;
      grant_id   <= '0;
      busy       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick_any) begin
            grant_id  <= pick_id;
            req_ready <= ONE << pick_id;
            busy      <= 1'b1;
            state     <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          req_ready <= '0;
          if (req_valid[grant_id]) begin
            tx_byte    <= req_data[grant_id*DATA_W +: DATA_W];
            last_grant <= grant_id;
            tx_trig    <= 1'b1;
            state      <= ST_TRIG;
          end else begin
            // producer withdrew: no transfer, rotation point untouched
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        end
        ST_TRIG: begin
          tx_trig  <= 1'b0;
          tick_cnt <= '0;
          state    <= ST_SEND;
        end
        ST_SEND: begin
          if (baud_tick) begin
            if (tick_cnt == FRAME_LAST) begin
              tick_cnt <= '0;
              if (GAP_TICKS == 0) begin
                busy  <= 1'b0;
                state <= ST_IDLE;
              end else begin
                state <= ST_GAP;
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end
        ST_GAP: begin
          if (baud_tick) begin
            if (tick_cnt == GAP_LAST) begin
              tick_cnt <= '0;
              busy     <= 1'b0;
              state    <= ST_IDLE;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end
        default: begin
          state     <= ST_IDLE;
          req_ready <= '0;
          tx_trig   <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: directed scenarios plus randomized producers,
// all checked every cycle against a timeline model of the scheduler.
module tb_uart_tx_sched;
  localparam int NR = 4, DW = 8, FT = 10, GT = 1;

  logic clk = 1'b0, rst = 1'b1, baud_tick = 1'b0;
  logic [NR-1:0]    req_valid = '0;
  logic [NR*DW-1:0] req_data  = '0;
  logic [NR-1:0]    req_ready;
  logic             tx_trig, busy;
  logic [DW-1:0]    tx_byte;
  logic [1:0]       grant_id;

  // second instance with no gap, fed by a producer that always has a byte
  logic [NR-1:0]    req_valid0 = '0;
  logic [NR*DW-1:0] req_data0  = '0;
  logic [NR-1:0]    req_ready0;
  logic             tx_trig0, busy0;
  logic [DW-1:0]    tx_byte0;
  logic [1:0]       grant_id0;

  uart_tx_sched #(.NUM_REQ(NR), .DATA_W(DW), .FRAME_TICKS(FT), .GAP_TICKS(GT)) u_dut (
    .clk(clk), .rst(rst), .baud_tick(baud_tick), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .tx_trig(tx_trig), .tx_byte(tx_byte), .grant_id(grant_id), .busy(busy));

  uart_tx_sched #(.NUM_REQ(NR), .DATA_W(DW), .FRAME_TICKS(FT), .GAP_TICKS(0)) u_dut0 (
    .clk(clk), .rst(rst), .baud_tick(baud_tick), .req_valid(req_valid0), .req_data(req_data0),
    .req_ready(req_ready0), .tx_trig(tx_trig0), .tx_byte(tx_byte0), .grant_id(grant_id0), .busy(busy0));

  always #2 clk = ~clk;

  // baud tick every 10 clocks, updated on posedge like a tick generator flop
  int bcnt = 0;
  always @(posedge clk) begin
    bcnt      <= (bcnt == 9) ? 0 : bcnt + 1;
    baud_tick <= (bcnt == 9);
  end

  int nchk = 0, nerr = 0;
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Busy span = ready cycle, trig cycle, then FT+GT counted ticks.
  logic [NR-1:0] m_ready;
  logic          m_trig, m_busy;
  logic [DW-1:0] m_byte;
  int            m_gid, m_last, m_step, m_ticks;

  function automatic int m_pick(input logic [NR-1:0] v, input int last);
    int j;
`ifdef UART_TX_SCHED_FIXED_PRIO_EN
    for (int i = 0; i < NR; i++) if (((v >> i) & 1) != 0) return i;
`else
    for (int k = 1; k <= NR; k++) begin
      j = (last + k) % NR;
      if (((v >> j) & 1) != 0) return j;
    end
`endif
    return 0;
  endfunction

  always @(posedge clk) begin
    int w;
    if (rst) begin
      m_ready <= '0; m_trig <= 1'b0; m_busy <= 1'b0; m_byte <= '0;
      m_gid <= 0; m_last <= NR - 1; m_step <= 0; m_ticks <= 0;
    end else if (!m_busy) begin
      if (req_valid != 0) begin
        w = m_pick(req_valid, m_last);
        m_gid <= w; m_ready <= NR'(1) << w; m_busy <= 1'b1; m_step <= 1;
      end
    end else if (m_step == 1) begin
      m_ready <= '0;
      if (req_valid[m_gid]) begin
        m_byte <= req_data[m_gid*DW +: DW]; m_last <= m_gid;
        m_trig <= 1'b1; m_step <= 2; m_ticks <= FT + GT;
      end else begin
        m_busy <= 1'b0; m_step <= 0;
      end
    end else if (m_step == 2) begin
      m_trig <= 1'b0; m_step <= 3;
    end else if (baud_tick) begin
      m_ticks <= m_ticks - 1;
      if (m_ticks == 1) begin m_busy <= 1'b0; m_step <= 0; end
    end
  end

  // ---------------- per-cycle compare + trigger log ----------------
  bit cmp_en = 0;
  int tg_q[$], tb_q[$];
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("ready",    32'(req_ready), 32'(m_ready));
      chk("trig",     32'(tx_trig),   32'(m_trig));
      chk("tx_byte",  32'(tx_byte),   32'(m_byte));
      chk("grant_id", 32'(grant_id),  32'(m_gid));
      chk("busy",     32'(busy),      32'(m_busy));
      if (tx_trig === 1'b1) begin
        tg_q.push_back(int'(grant_id));
        tb_q.push_back(int'(tx_byte));
      end
    end
  end

  // ---------------- producers ----------------
  bit          rnd_mode = 0;
  bit [NR-1:0] served = '0, drop_on_ready = '0;

  task automatic cyc();
    @(negedge clk);
    for (int i = 0; i < NR; i++) if (served[i]) begin req_valid[i] = 1'b0; served[i] = 1'b0; end
    if (rnd_mode)
      for (int i = 0; i < NR; i++)
        if (!req_valid[i] && $urandom_range(0, 7) == 0) begin
          req_valid[i] = 1'b1;
          req_data[i*DW +: DW] = DW'($urandom);
        end
    for (int i = 0; i < NR; i++)
      if (req_ready[i] === 1'b1) begin
        if (drop_on_ready[i]) req_valid[i] = 1'b0;
        else served[i] = 1'b1;
      end
  endtask

  task automatic req(input int i, input logic [DW-1:0] d);
    req_valid[i] = 1'b1;
    req_data[i*DW +: DW] = d;
  endtask

  task automatic wait_idle(input int maxc);
    int n = 0;
    do begin cyc(); n++; end
    while (!(req_valid == 0 && busy === 1'b0 && !m_busy) && n < maxc);
    if (n >= maxc) chk("wait_idle_timeout", 32'(n), 32'(0));
  endtask

  initial begin
    int nt, n;
    req_valid0 = 4'b0001;
    req_data0  = 32'h0000_005A;
    repeat (3) @(negedge clk);
    cmp_en = 1;
    cyc();
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_trig",  32'(tx_trig),   0);
    chk("rst_byte",  32'(tx_byte),   0);
    chk("rst_gid",   32'(grant_id),  0);
    chk("rst_busy",  32'(busy),      0);
    rst = 1'b0;

    // zero gap: next trig exactly 10 ticks + 3 clk after the previous one
    n = 0;
    do begin cyc(); n++; end while (tx_trig0 !== 1'b1 && n < 300);
    chk("gap0_first_trig", 32'(tx_trig0), 1);
    chk("gap0_byte", 32'(tx_byte0), 32'h5A);
    nt = 0; n = 0;
    while (nt < 10 && n < 300) begin
      cyc(); n++;
      if (tx_trig0 === 1'b1) chk("gap0_early_trig", 1, 0);
      if (baud_tick) nt++;
    end
    chk("gap0_ticks", 32'(nt), 10);
    cyc(); chk("gap0_trig_p1", 32'(tx_trig0), 0);
    cyc(); chk("gap0_trig_p2", 32'(tx_trig0), 0);
    cyc(); chk("gap0_trig_p3", 32'(tx_trig0), 1);

    // contention straight after reset: 0,1,2,3
    tg_q.delete(); tb_q.delete();
    for (int i = 0; i < NR; i++) req(i, 8'hA0 + 8'(i));
    wait_idle(2000);
    chk("cont_count", 32'(tg_q.size()), 4);
    for (int i = 0; i < NR && i < tg_q.size(); i++) begin
      chk("cont_gid",  32'(tg_q[i]), 32'(i));
      chk("cont_byte", 32'(tb_q[i]), 32'(8'hA0 + 8'(i)));
    end

    // single request on requester 0
    tg_q.delete(); tb_q.delete();
    req(0, 8'h55);
    cyc(); chk("single_ready", 32'(req_ready), 32'b0001);
    cyc(); chk("single_trig", 32'(tx_trig), 1);
    chk("single_byte", 32'(tx_byte), 32'h55);
    nt = 0; n = 0;
    while (n < 400) begin
      cyc(); n++;
      if (busy !== 1'b1) break;
      if (baud_tick) nt++;
    end
    chk("single_busy_ticks", 32'(nt), 11);
    wait_idle(400);
    chk("single_count", 32'(tg_q.size()), 1);

    // rotation: serve 2, then 1 and 3 together
    req(2, 8'h22);
    wait_idle(400);
    tg_q.delete(); tb_q.delete();
    req(1, 8'h11); req(3, 8'h33);
    wait_idle(800);
    chk("rot_count", 32'(tg_q.size()), 2);
`ifdef UART_TX_SCHED_FIXED_PRIO_EN
    if (tg_q.size() == 2) begin chk("rot_first", 32'(tg_q[0]), 1); chk("rot_second", 32'(tg_q[1]), 3); end
`else
    if (tg_q.size() == 2) begin chk("rot_first", 32'(tg_q[0]), 3); chk("rot_second", 32'(tg_q[1]), 1); end
`endif

    // valid drop in the grant cycle
    req(0, 8'h0F);
    wait_idle(400);
    tg_q.delete(); tb_q.delete();
    drop_on_ready[1] = 1'b1;
    req(1, 8'h77);
    wait_idle(100);
    chk("drop_no_trig", 32'(tg_q.size()), 0);
    drop_on_ready = '0;
    req(1, 8'h71); req(2, 8'h72);
    wait_idle(800);
    chk("drop_next_count", 32'(tg_q.size()), 2);
    if (tg_q.size() > 0) chk("drop_next_gid", 32'(tg_q[0]), 1);

    // reset 5 ticks into the frame
    req(0, 8'h99);
    n = 0;
    do begin cyc(); n++; end while (tx_trig !== 1'b1 && n < 50);
    chk("rstmid_trig", 32'(tx_trig), 1);
    nt = 0; n = 0;
    while (nt < 5 && n < 200) begin cyc(); n++; if (baud_tick) nt++; end
    cyc();
    rst = 1'b1;
    cyc();
    chk("rstmid_ready", 32'(req_ready), 0);
    chk("rstmid_trig0", 32'(tx_trig),   0);
    chk("rstmid_byte",  32'(tx_byte),   0);
    chk("rstmid_gid",   32'(grant_id),  0);
    chk("rstmid_busy",  32'(busy),      0);
    rst = 1'b0;
    tg_q.delete(); tb_q.delete();
    req(3, 8'h3C);
    cyc();
    chk("rstmid_regrant_ready", 32'(req_ready), 32'b1000);
    chk("rstmid_regrant_gid",   32'(grant_id),  3);
    wait_idle(400);
    if (tb_q.size() > 0) chk("rstmid_regrant_byte", 32'(tb_q[0]), 32'h3C);
    else chk("rstmid_regrant_count", 0, 1);

    // randomized producers
    rnd_mode = 1;
    repeat (3000) cyc();
    rnd_mode = 0;
    wait_idle(3000);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/uart_tx_sched.md
# uart_tx_sched

Round-robin scheduler sharing one `uart_tx` transmitter among `NUM_REQ` byte producers. It accepts one byte per valid/ready handshake, drives the transmitter's start trigger and byte input, and holds off further grants until the frame has been sent. Frame completion is tracked by counting `baud_tick` pulses from `Baud_tick_gen`. The block sits between the producers and `uart_tx`; it observes `baud_tick` but does not drive it.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `DATA_W`, 8: byte width.
- `FRAME_TICKS`, 10: `baud_tick` pulses per frame (start + 8 data + stop).
- `GAP_TICKS`, 1: idle `baud_tick` pulses enforced after each frame. 0 means no gap.
- `clk` in 1: system clock. One clock domain only.
- `rst` in 1: reset, synchronous, active-high.
- `baud_tick` in 1: one-cycle pulse from `Baud_tick_gen`.
- `req_valid` in NUM_REQ: producer i has a byte.
- `req_data` in NUM_REQ*DATA_W: byte i occupies bits [i*DATA_W +: DATA_W].
- `req_ready` out NUM_REQ: one-hot accept pulse.
- `tx_trig` out 1: start pulse to `uart_tx`.
- `tx_byte` out DATA_W: byte to `uart_tx`. Stable from TRIG until the next grant.
- `grant_id` out clog2(NUM_REQ): index of the current or last granted requester.
- `busy` out 1: high whenever state ≠ IDLE.

## Operation
- FSM states: IDLE, GRANT, TRIG, SEND, GAP.
- IDLE:
  - If `|req_valid`, select the winner. Round-robin search starts at `last_grant+1` mod NUM_REQ.
  - Register the winner in `grant_id`, then go to GRANT.
  - If no request is valid, stay in IDLE.
- GRANT: `req_ready[grant_id]` = 1 for exactly this cycle.
  - If `req_valid[grant_id]` is high at the closing edge, latch `req_data[grant_id]` into `tx_byte`, update `last_grant`, and go to TRIG.
  - If `req_valid[grant_id]` has dropped (protocol violation), return to IDLE. No transfer occurs and `last_grant` is unchanged.
- TRIG: `tx_trig` = 1 for one cycle, then go to SEND. Clear `tick_cnt`.
- SEND:
  - Increment `tick_cnt` on each `baud_tick`.
  - On the tick that makes `tick_cnt == FRAME_TICKS`, clear `tick_cnt` and go to GAP.
  - If `GAP_TICKS == 0`, go to IDLE instead.
- GAP: count `baud_tick`. On the tick that makes the count reach GAP_TICKS, go to IDLE.
- `baud_tick` pulses during IDLE, GRANT and TRIG are ignored.
- Producers must hold `req_valid` and data until `req_ready` is seen. A producer may re-assert `req_valid` in the cycle after its `req_ready`.
- `tick_cnt` width is clog2(max(FRAME_TICKS, GAP_TICKS)+1) and never wraps.
- Outputs in each state:
  - `req_ready` is 0 outside GRANT.
  - `tx_trig` is 0 outside TRIG.

## Timing
- Reset values:
  - `req_ready` = 0, `tx_trig` = 0, `tx_byte` = 0, `grant_id` = 0, `busy` = 0.
  - State = IDLE, `tick_cnt` = 0.
  - `last_grant` = NUM_REQ-1, so requester 0 wins first.
- Latency: `req_valid` seen high in IDLE at edge k:
  - `req_ready` is high in cycle k+1.
  - `tx_trig` is high in cycle k+2.
  - The earliest next grant is FRAME_TICKS+GAP_TICKS ticks after TRIG, plus one cycle.
- Simultaneous requests: exactly one grant per frame. The remaining requesters keep `req_valid` high and are served in rotation.
- `rst` asserted in any state takes effect at the next edge:
  - Return to IDLE with all outputs at their reset values.
  - Any partially counted frame is abandoned. The sched does not wait for `uart_tx` to finish.
- Throughput ceiling: one byte per (FRAME_TICKS+GAP_TICKS) baud periods plus 3 clocks.

## Configuration
- `UART_TX_SCHED_FIXED_PRIO_EN`:
  - Defined: fixed priority, lowest index wins every time. `last_grant` is not used for selection.
  - Undefined: round-robin as described under Operation.
- All handshake and FSM timing is identical in both builds.

## Structure
- The shared package `uart_pkg` holds:
  - the state encoding constants (IDLE=0, GRANT=1, TRIG=2, SEND=3, GAP=4);
  - the default FRAME_TICKS, GAP_TICKS and DATA_W constants, which `uart_tx` also uses.
- One sub-module, `uart_rr_pick`: combinational winner select from `req_valid` and `last_grant`.
  - The `UART_TX_SCHED_FIXED_PRIO_EN` switch lives inside `uart_rr_pick`.
  - FSM, counters and registers stay in `uart_tx_sched`.

## Test plan
All scenarios use 4-cycle `clk`, `Baud_tick_gen` with BAUD_COUNT=10, and defaults.
- Single request: `req_valid` = 4'b0001 with byte 8'h55. Required:
  - `req_ready` = 4'b0001 for one cycle;
  - `tx_trig` one cycle later with `tx_byte` = 8'h55;
  - `busy` high for 11 ticks (+3 clk);
  - the `uart_tx` line shows 0, 1,0,1,0,1,0,1,0, then 1.
- Contention: all four requesters valid with bytes 8'hA0..8'hA3. Required:
  - grants in order 0,1,2,3;
  - exactly one `tx_trig` per frame;
  - no `req_ready` pulse while `busy`.
- Rotation: requester 2 is served, then requesters 1 and 3 both request. Required: requester 3 is granted before requester 1. The `UART_TX_SCHED_FIXED_PRIO_EN` build grants 1 first.
- Valid drop: requester 1 drops `req_valid` in its GRANT cycle. Required:
  - no `tx_trig`;
  - return to IDLE;
  - requester 1 is still next in rotation.
- Reset mid-frame: assert `rst` 5 ticks into SEND. Required:
  - all outputs are 0 at the next edge;
  - after release, a request on requester 3 is granted normally, with `grant_id` = 3.
- `GAP_TICKS`=0: back-to-back requests from requester 0. Required: the second `tx_trig` occurs exactly 10 ticks + 3 clk after the first.
